// File: rtl/led_breather_pkg.sv
// Shared types and sizing helpers for the breathing-LED stage.
// Pure declarations: no logic, no latency, no flow control.
package led_breather_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  function automatic int pwm_max(input int width);
    return (1 << width) - 1;
  endfunction

  // A single-tick hold still needs a 1-bit counter to compare against zero.
  function automatic int hold_width(input int ticks);
    return (ticks <= 1) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/led_breather_pwm_core.sv
// Free-running PWM counter with period-aligned duty shadow; output registered (1 cycle).
// No backpressure: duty changes are absorbed at the next wrap, never mid-period.
module pwm_core
  import led_breather_pkg::*;
#(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [PWM_WIDTH-1:0] duty,
  input  logic                 gate,
  output logic                 pwm,
  output logic                 period_start
);

  localparam logic [PWM_WIDTH-1:0] CNT_MAX = PWM_WIDTH'(pwm_max(PWM_WIDTH));

  logic [PWM_WIDTH-1:0] counter;
  logic [PWM_WIDTH-1:0] duty_active;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter     <= '0;
      duty_active <= '0;
      pwm         <= 1'b0;
    end else begin
      counter <= counter + 1'b1;
      // Reload only at the wrap so a period never mixes two duty values.
      if (counter == CNT_MAX) duty_active <= duty;
      pwm <= gate && (counter < duty_active);
    end
  end

  assign period_start = (counter == '0);

endmodule

// File: rtl/led_breather.sv
// Triangle duty ramp with end holds, stepped by each edge of io_blink; 1-edge tick-to-duty latency.
// No backpressure: every blink edge is consumed; io_enable low aborts to IDLE with priority.
module led_breather
  import led_breather_pkg::*;
#(
  parameter int PWM_WIDTH  = 8,
  parameter int STEP       = 16,
  parameter int HOLD_TICKS = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 io_enable,
  input  logic                 io_blink,
  output logic                 io_led_pwm,
  output logic [PWM_WIDTH-1:0] io_duty,
  output logic [2:0]           io_state,
  output logic                 io_period_start
);

  localparam int                   HW        = hold_width(HOLD_TICKS);
  localparam logic [PWM_WIDTH-1:0] DUTY_MAX  = PWM_WIDTH'(pwm_max(PWM_WIDTH));
  localparam logic [PWM_WIDTH-1:0] STEP_N    = PWM_WIDTH'(STEP);
  localparam logic [PWM_WIDTH:0]   STEP_X    = (PWM_WIDTH + 1)'(STEP);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_TICKS - 1);

  state_t               state;
  logic [HW-1:0]        hold;
  logic                 blink_q;
  logic                 tick;
  logic [PWM_WIDTH:0]   up_sum;
  logic [PWM_WIDTH-1:0] up_duty;
  logic [PWM_WIDTH-1:0] down_duty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) blink_q <= 1'b0;
    else          blink_q <= io_blink;
  end

  assign tick      = io_blink ^ blink_q;
  assign up_sum    = {1'b0, io_duty} + STEP_X;
  assign up_duty   = (up_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : up_sum[PWM_WIDTH-1:0];
  assign down_duty = (io_duty >= STEP_N) ? (io_duty - STEP_N) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      io_duty <= '0;
      hold    <= '0;
    end else if (state != IDLE && !io_enable) begin
      state   <= IDLE;
      io_duty <= '0;
      hold    <= '0;
    end else begin
      case (state)
        IDLE: if (io_enable) state <= RAMP_UP;
        RAMP_UP: if (tick) begin
          io_duty <= up_duty;
          if (up_duty == DUTY_MAX) begin
            state <= HOLD_HIGH;
            hold  <= '0;
          end
        end
        HOLD_HIGH: if (tick) begin
          if (hold == HOLD_LAST) begin
            state <= RAMP_DOWN;
            hold  <= '0;
          end else hold <= hold + 1'b1;
        end
        RAMP_DOWN: if (tick) begin
          io_duty <= down_duty;
          if (down_duty == '0) begin
            state <= HOLD_LOW;
            hold  <= '0;
          end
        end
        HOLD_LOW: if (tick) begin
          if (hold == HOLD_LAST) begin
            state <= RAMP_UP;
            hold  <= '0;
          end else hold <= hold + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_state = state;

  pwm_core #(.PWM_WIDTH(PWM_WIDTH)) u_pwm (
    .clock        (clock),
    .reset_n      (reset_n),
    .duty         (io_duty),
    .gate         (state != IDLE),
    .pwm          (io_led_pwm),
    .period_start (io_period_start)
  );

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather: scoreboarded duty/state per blink edge plus PWM period measurements.
module tb_led_breather;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       io_enable;
  logic       io_blink;
  logic       io_led_pwm;
  logic [7:0] io_duty;
  logic [2:0] io_state;
  logic       io_period_start;

  typedef struct {
    logic [7:0] duty;
    logic [2:0] state;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  led_breather #(.PWM_WIDTH(8), .STEP(16), .HOLD_TICKS(2)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .io_enable       (io_enable),
    .io_blink        (io_blink),
    .io_led_pwm      (io_led_pwm),
    .io_duty         (io_duty),
    .io_state        (io_state),
    .io_period_start (io_period_start)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input logic [7:0] d, input logic [2:0] s);
    exp_t e;
    e.duty  = d;
    e.state = s;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_duty"}, io_duty, e.duty);
      check({tag, "_state"}, io_state, e.state);
    end
  endtask

  // One blink edge, checked one edge later, then idle to a 10-cycle spacing.
  task automatic toggle_step(input string tag, input logic [7:0] d, input logic [2:0] s);
    expect_push(d, s);
    @(negedge clock);
    io_blink = ~io_blink;
    @(negedge clock);
    sb_check(tag);
    repeat (8) @(negedge clock);
  endtask

  task automatic wait_ps();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (io_period_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("period_start_timeout", 0, 1);
  endtask

  // Samples one full period starting at the period_start cycle.
  task automatic measure(input bit do_tick, output int highs, output int first_hi);
    highs    = 0;
    first_hi = -1;
    wait_ps();
    for (int off = 0; off < 256; off++) begin
      if (off > 0) @(negedge clock);
      if (io_led_pwm === 1'b1) begin
        highs++;
        if (first_hi < 0) first_hi = off;
      end
      if (do_tick && off == 101) sb_check("mid_tick");
      if (do_tick && off == 100) io_blink = ~io_blink;
    end
  endtask

  initial begin
    int hi;
    int first;
    reset_n   = 1'b0;
    io_enable = 1'b0;
    io_blink  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_state", io_state, 0);
    check("rst_duty", io_duty, 0);
    check("rst_pwm", io_led_pwm, 0);
    check("rst_period_start", io_period_start, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    io_enable = 1'b1;
    expect_push(8'd0, 3'd1);
    @(negedge clock);
    sb_check("enable");

    for (int i = 1; i <= 16; i++)
      toggle_step("ramp_up", (i < 16) ? 8'(16 * i) : 8'd255, (i < 16) ? 3'd1 : 3'd2);

    toggle_step("hold_high1", 8'd255, 3'd2);
    toggle_step("hold_high2", 8'd255, 3'd3);
    for (int i = 1; i <= 16; i++)
      toggle_step("ramp_down", (i < 16) ? 8'(255 - 16 * i) : 8'd0, (i < 16) ? 3'd3 : 3'd4);
    toggle_step("hold_low1", 8'd0, 3'd4);
    toggle_step("hold_low2", 8'd0, 3'd1);
    for (int i = 1; i <= 4; i++)
      toggle_step("reramp", 8'(16 * i), 3'd1);

    wait_ps();
    measure(1'b0, hi, first);
    check("pwm64_highs", hi, 64);
    check("pwm64_rise", first, 1);

    expect_push(8'd80, 3'd1);
    measure(1'b1, hi, first);
    check("mid_update_old_highs", hi, 64);
    measure(1'b0, hi, first);
    check("mid_update_new_highs", hi, 80);
    check("pwm80_rise", first, 1);

    wait_ps();
    repeat (10) @(negedge clock);
    check("pre_drop_pwm", io_led_pwm, 1);
    expect_push(8'd0, 3'd0);
    io_enable = 1'b0;
    io_blink  = ~io_blink;
    @(negedge clock);
    sb_check("enable_drop");
    @(negedge clock);
    check("drop_pwm_low", io_led_pwm, 0);
    toggle_step("idle_tick", 8'd0, 3'd0);
    check("idle_pwm", io_led_pwm, 0);

    io_enable = 1'b1;
    expect_push(8'd0, 3'd1);
    @(negedge clock);
    sb_check("reenable");
    for (int i = 1; i <= 6; i++)
      toggle_step("ramp96", 8'(16 * i), 3'd1);
    wait_ps();
    repeat (20) @(negedge clock);
    check("pre_reset_pwm", io_led_pwm, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_state", io_state, 0);
    check("async_rst_duty", io_duty, 0);
    check("async_rst_pwm", io_led_pwm, 0);
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_breather.md
# led_breather

Breathing-LED stage that sits directly downstream of the blink divider. It consumes the divider's slowly toggling LED level as a step clock and ramps a PWM duty cycle up and down (triangle with holds at the extremes). It drives a physical LED pin with a glitch-free PWM waveform.

## Interface
- PWM_WIDTH, 8: width of the PWM counter and duty value; period = 2^PWM_WIDTH cycles; PWM_MAX = 2^PWM_WIDTH-1
- STEP, 16: duty increment/decrement per step tick; 1 ≤ STEP ≤ PWM_MAX
- HOLD_TICKS, 2: step ticks spent in each hold state; ≥ 1
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_enable  in  1  level; low forces IDLE
- io_blink  in  1  toggling level from the blink divider; every change (either direction) is one step tick
- io_led_pwm  out  1  registered PWM output
- io_duty  out  PWM_WIDTH  current target duty
- io_state  out  3  FSM state encoding
- io_period_start  out  1  one-cycle pulse in the cycle where the PWM counter is 0

## Operation
- Reset (async on reset_n low): state IDLE, io_duty 0, duty_active 0, counter 0, hold 0, blink_q 0, io_led_pwm 0.
- Tick detect: blink_q <= io_blink every cycle. tick = io_blink ^ blink_q (combinational). If io_blink is already 1 at reset release, one tick is seen on the first edge; this is permitted.
- State encodings: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
- Transitions:
  - IDLE: moves to RAMP_UP when io_enable is 1. Ticks in IDLE are ignored; duty is unchanged.
  - RAMP_UP: on a tick, duty <= min(duty+STEP, PWM_MAX), using a (PWM_WIDTH+1)-bit sum. If the result equals PWM_MAX, go to HOLD_HIGH with hold <= 0.
  - HOLD_HIGH: on a tick, if hold == HOLD_TICKS-1, go to RAMP_DOWN with hold <= 0; otherwise hold++.
  - RAMP_DOWN: on a tick, duty <= max(duty−STEP, 0), with no underflow. If the result is 0, go to HOLD_LOW with hold <= 0.
  - HOLD_LOW: same as HOLD_HIGH, but exits to RAMP_UP.
- io_enable is 0 in any non-IDLE state: next edge gives state IDLE, duty 0, hold 0. This takes priority over a simultaneous tick.
- PWM counter: free-running PWM_WIDTH bits, increments every cycle, wraps PWM_MAX to 0.
- duty_active is the shadow of io_duty. It is loaded only at the edge where the counter equals PWM_MAX.
  - If a duty update and the reload occur on the same edge, duty_active takes the old io_duty.
- io_led_pwm <= (state != IDLE) && (counter < duty_active).
  - duty 0: output always low.
  - duty PWM_MAX: output high for 255 of 256 cycles.

## Timing
- Tick to io_duty/io_state: updates on the first rising edge at which io_blink differs from blink_q (1 edge).
- io_duty to output: a new duty affects io_led_pwm starting the period after the next counter wrap. The output is never changed mid-period by a duty update.
- io_led_pwm is registered: it reflects the compare of the counter and duty_active from the previous cycle.
- Entering IDLE: io_led_pwm is 0 from the edge after the state register shows IDLE.
- io_period_start = (counter == 0), combinational from a register, high 1 of every 2^PWM_WIDTH cycles.
- Ticks arrive at most once per cycle. Consecutive-cycle ticks are each honored.

## Structure
- Package led_breather_pkg holds:
  - state enum, 3 bits, encodings as above
  - PWM_MAX helper function
  - hold-counter width function clog2(HOLD_TICKS)
- Sub-module pwm_core contains the counter, duty_active shadow, compare, output register and period_start.
  - Ports: clock, reset_n, duty, gate, pwm, period_start.
- The top level holds the tick detect, FSM, duty arithmetic and hold counter.

## Test plan
- Reset mid-ramp: with duty 96, assert reset_n low between edges. All outputs drop to 0 and io_state to 0 immediately, without waiting for a clock edge.
- Full ramp: io_enable 1, 16 io_blink toggles spaced 10 cycles apart. io_duty steps 16, 32, …, 240, 255; io_state goes 1 then 2 after the 16th toggle.
- Hold/down (HOLD_TICKS 2):
  - 2 further toggles: io_duty stays 255, io_state 3.
  - 3rd toggle: io_duty 239.
  - The 16th toggle in RAMP_DOWN (15 to 0) gives io_state 4, io_duty 0.
- PWM accuracy: hold duty 64 with no toggles. io_led_pwm is high exactly 64 cycles per 256-cycle period, and rises one cycle after io_period_start.
- Mid-period update: a tick when the counter is 100 (duty 64 to 80). The current period still shows 64 high cycles; the period after the next wrap shows 80.
- Enable drop with simultaneous tick: io_state becomes 0 and io_duty 0, the tick is ignored, and io_led_pwm goes low on the next edge.
